// File: rtl/ctrl_maquina_bebidas_if.sv
// Bundle between the user panel / dispensers and the drink sequencer.
// master: panel and dispenser side (drives start, recipe, fin_*); slave: the sequencer.
// Optional CTRL_CANCEL_EN adds the cancel request line.
interface ctrl_maquina_bebidas_if;
   logic       start;
   logic [1:0] bebida;
   logic [1:0] nivel_azucar;
   logic       fin_agua;
   logic       fin_cafe;
   logic       fin_leche;
   logic       fin_azucar;
   logic       clear_err;
`ifdef CTRL_CANCEL_EN
   logic       cancel;
`endif
   logic       enable_agua;
   logic       enable_cafe;
   logic       enable_leche;
   logic       enable_azucar;
   logic [1:0] bebida_lat;
   logic [1:0] azucar_lat;
   logic       ocupado;
   logic       listo;
   logic       error;

   modport master (
      output start, bebida, nivel_azucar,
      output fin_agua, fin_cafe, fin_leche, fin_azucar, clear_err,
`ifdef CTRL_CANCEL_EN
      output cancel,
`endif
      input  enable_agua, enable_cafe, enable_leche, enable_azucar,
      input  bebida_lat, azucar_lat, ocupado, listo, error
   );

   modport slave (
      input  start, bebida, nivel_azucar,
      input  fin_agua, fin_cafe, fin_leche, fin_azucar, clear_err,
`ifdef CTRL_CANCEL_EN
      input  cancel,
`endif
      output enable_agua, enable_cafe, enable_leche, enable_azucar,
      output bebida_lat, azucar_lat, ocupado, listo, error
   );
endinterface

// File: rtl/ctrl_maquina_bebidas.sv
// Drink sequencer: runs agua/cafe/leche/azucar dispensers one at a time per recipe, with per-stage watchdog.
// Latency: start to listo = 1 + sum(stage cycles) + 1; all outputs registered, decoded from next state.
// Backpressure: each stage holds its enable until the dispenser's fin; optional macro CTRL_CANCEL_EN adds cancel.
module ctrl_maquina_bebidas #(
   parameter int TIMEOUT_CYC = 16
) (
   input logic                   clk,
   input logic                   rst,
   ctrl_maquina_bebidas_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, AGUA, CAFE, LECHE, AZUCAR, DONE, ERROR
   } state_t;

   localparam logic [7:0] TMAX = 8'(TIMEOUT_CYC - 1);

   state_t     state, state_nxt;
   logic [7:0] timer, timer_nxt;
   logic [1:0] beb_q, beb_nxt;
   logic [1:0] az_q, az_nxt;
   logic       fin_act;
   logic [3:0] en_q, en_nxt;
   logic       ocupado_q, listo_q, error_q;

   // Next stage after 'cur' in the fixed order; later lines override, so the earliest pending stage wins.
   function automatic state_t siguiente(input state_t cur, input logic [1:0] b, input logic [1:0] a);
      state_t r;
      r = DONE;
      if (a != 2'd0 && (cur == IDLE || cur == AGUA || cur == CAFE || cur == LECHE)) r = AZUCAR;
      if (b != 2'd0 && (cur == IDLE || cur == AGUA || cur == CAFE))                 r = LECHE;
      if (b != 2'd3 && (cur == IDLE || cur == AGUA))                                r = CAFE;
      if (b != 2'd2 && cur == IDLE)                                                  r = AGUA;
      return r;
   endfunction

   // Next-state, watchdog and latch logic; output values are decoded from the next state.
   always_comb begin
      state_nxt = state;
      timer_nxt = 8'd0;
      beb_nxt   = beb_q;
      az_nxt    = az_q;
      fin_act   = 1'b0;

      case (state)
         AGUA:    fin_act = bus.fin_agua;
         CAFE:    fin_act = bus.fin_cafe;
         LECHE:   fin_act = bus.fin_leche;
         AZUCAR:  fin_act = bus.fin_azucar;
         default: fin_act = 1'b0;
      endcase

      case (state)
         IDLE: begin
            if (bus.start) begin
               beb_nxt   = bus.bebida;
               az_nxt    = bus.nivel_azucar;
               state_nxt = siguiente(IDLE, bus.bebida, bus.nivel_azucar);
            end
         end
         AGUA, CAFE, LECHE, AZUCAR: begin
`ifdef CTRL_CANCEL_EN
            if (bus.cancel) begin
               state_nxt = IDLE;
            end else
`endif
            if (fin_act) begin
               // fin beats the watchdog when both land on the same cycle
               state_nxt = siguiente(state, beb_q, az_q);
            end else if (timer == TMAX) begin
               state_nxt = ERROR;
            end else begin
               timer_nxt = timer + 8'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         ERROR: begin
            if (bus.clear_err) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      en_nxt = {state_nxt == AGUA, state_nxt == CAFE, state_nxt == LECHE, state_nxt == AZUCAR};
   end

   // State, timer, latched order and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= 8'd0;
         beb_q     <= 2'd0;
         az_q      <= 2'd0;
         en_q      <= 4'd0;
         ocupado_q <= 1'b0;
         listo_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         beb_q     <= beb_nxt;
         az_q      <= az_nxt;
         en_q      <= en_nxt;
         ocupado_q <= (state_nxt != IDLE);
         listo_q   <= (state_nxt == DONE);
         error_q   <= (state_nxt == ERROR);
      end
   end

   assign bus.enable_agua   = en_q[3];
   assign bus.enable_cafe   = en_q[2];
   assign bus.enable_leche  = en_q[1];
   assign bus.enable_azucar = en_q[0];
   assign bus.bebida_lat    = beb_q;
   assign bus.azucar_lat    = az_q;
   assign bus.ocupado       = ocupado_q;
   assign bus.listo         = listo_q;
   assign bus.error         = error_q;

endmodule

// File: tb/tb_ctrl_maquina_bebidas.sv
// Directed bench for the drink sequencer: recipes, stale fin, watchdog boundary, error clear, optional cancel.
// Inputs change 1 time unit after posedge; outputs are sampled at the same point.
// Enable vector is shown as {agua, cafe, leche, azucar}.
module tb_ctrl_maquina_bebidas;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] fins;
   logic [3:0] en;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   ctrl_maquina_bebidas_if bus();

   ctrl_maquina_bebidas #(.TIMEOUT_CYC(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.fin_agua   = fins[3];
   assign bus.fin_cafe   = fins[2];
   assign bus.fin_leche  = fins[1];
   assign bus.fin_azucar = fins[0];
   assign en = {bus.enable_agua, bus.enable_cafe, bus.enable_leche, bus.enable_azucar};

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Stage already entered: check enable for 3 cycles, raise fin on the third; optionally leave it high.
   task automatic stage(input string tag, input logic [3:0] exp_en, input int idx, input bit hold);
      chk({tag, "_en0"}, int'(en), int'(exp_en));
      chk({tag, "_ocup"}, int'(bus.ocupado), 1);
      tick;
      chk({tag, "_en1"}, int'(en), int'(exp_en));
      tick;
      chk({tag, "_en2"}, int'(en), int'(exp_en));
      fins[idx] = 1'b1;
      tick;
      if (!hold) fins[idx] = 1'b0;
   endtask

   initial begin
      fins             = 4'd0;
      bus.start        = 1'b1;
      bus.bebida       = 2'd1;
      bus.nivel_azucar = 2'd3;
      bus.clear_err    = 1'b0;
`ifdef CTRL_CANCEL_EN
      bus.cancel       = 1'b0;
`endif
      rst = 1'b1;

      // Reset held 2 cycles with start asserted
      tick;
      tick;
      chk("rst_ocupado", int'(bus.ocupado), 0);
      chk("rst_en", int'(en), 0);
      chk("rst_listo", int'(bus.listo), 0);
      chk("rst_error", int'(bus.error), 0);
      chk("rst_beblat", int'(bus.bebida_lat), 0);
      chk("rst_azlat", int'(bus.azucar_lat), 0);
      rst = 1'b0;
      bus.start = 1'b0;
      tick;
      chk("idle_ocupado", int'(bus.ocupado), 0);
      chk("idle_en", int'(en), 0);

      // con_leche with 2 sugar; inputs changed right after start must not matter
      bus.bebida = 2'd1; bus.nivel_azucar = 2'd2; bus.start = 1'b1;
      tick;
      bus.start = 1'b0; bus.bebida = 2'd0; bus.nivel_azucar = 2'd0;
      chk("a_beblat", int'(bus.bebida_lat), 1);
      chk("a_azlat", int'(bus.azucar_lat), 2);
      stage("a_agua",   4'b1000, 3, 1'b0);
      stage("a_cafe",   4'b0100, 2, 1'b0);
      stage("a_leche",  4'b0010, 1, 1'b0);
      stage("a_azucar", 4'b0001, 0, 1'b0);
      chk("a_listo", int'(bus.listo), 1);
      chk("a_done_en", int'(en), 0);
      chk("a_done_ocup", int'(bus.ocupado), 1);
      tick;
      chk("a_listo_off", int'(bus.listo), 0);
      chk("a_idle_ocup", int'(bus.ocupado), 0);

      // capuchino, no sugar: cafe then leche only
      bus.bebida = 2'd2; bus.nivel_azucar = 2'd0; bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      stage("b_cafe",  4'b0100, 2, 1'b0);
      stage("b_leche", 4'b0010, 1, 1'b0);
      chk("b_listo", int'(bus.listo), 1);
      chk("b_done_en", int'(en), 0);
      tick;
      chk("b_idle_ocup", int'(bus.ocupado), 0);

      // negro: fin on the last watchdog cycle wins, then cafe times out
      bus.bebida = 2'd0; bus.nivel_azucar = 2'd0; bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      chk("c_agua_en", int'(en), 8);
      repeat (15) tick;
      chk("c_agua_late", int'(en), 8);
      fins[3] = 1'b1;
      tick;
      fins[3] = 1'b0;
      chk("c_fin_wins_en", int'(en), 4);
      chk("c_fin_wins_err", int'(bus.error), 0);
      repeat (15) tick;
      chk("c_cafe_hold", int'(en), 4);
      chk("c_cafe_noerr", int'(bus.error), 0);
      tick;
      chk("c_timeout_err", int'(bus.error), 1);
      chk("c_timeout_en", int'(en), 0);
      chk("c_timeout_ocup", int'(bus.ocupado), 1);
      chk("c_timeout_listo", int'(bus.listo), 0);
      bus.start = 1'b1;
      tick;
      chk("c_start_ignored", int'(bus.error), 1);
      bus.clear_err = 1'b1;
      tick;
      bus.clear_err = 1'b0;
      bus.start = 1'b0;
      chk("c_clear_err", int'(bus.error), 0);
      chk("c_clear_ocup", int'(bus.ocupado), 0);
      chk("c_clear_en", int'(en), 0);
      tick;
      chk("c_still_idle", int'(bus.ocupado), 0);

      // Stale fin_agua held through cafe, start pulsed mid-order
      bus.bebida = 2'd0; bus.nivel_azucar = 2'd1; bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      chk("d_agua_en", int'(en), 8);
      tick;
      fins[3] = 1'b1;
      tick;
      chk("d_cafe_en", int'(en), 4);
      bus.start = 1'b1; bus.bebida = 2'd3;
      tick;
      bus.start = 1'b0;
      tick;
      tick;
      chk("d_cafe_wait", int'(en), 4);
      chk("d_beblat", int'(bus.bebida_lat), 0);
      fins[2] = 1'b1;
      tick;
      fins[2] = 1'b0;
      chk("d_azucar_en", int'(en), 1);
      fins[3] = 1'b0;
      fins[0] = 1'b1;
      tick;
      fins[0] = 1'b0;
      chk("d_listo", int'(bus.listo), 1);
      tick;
      chk("d_idle_ocup", int'(bus.ocupado), 0);

`ifdef CTRL_CANCEL_EN
      // Cancel during leche
      bus.bebida = 2'd1; bus.nivel_azucar = 2'd0; bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      stage("e_agua", 4'b1000, 3, 1'b0);
      stage("e_cafe", 4'b0100, 2, 1'b0);
      chk("e_leche_en", int'(en), 2);
      bus.cancel = 1'b1;
      tick;
      bus.cancel = 1'b0;
      chk("e_cancel_en", int'(en), 0);
      chk("e_cancel_ocup", int'(bus.ocupado), 0);
      chk("e_cancel_listo", int'(bus.listo), 0);
      chk("e_cancel_err", int'(bus.error), 0);
      tick;
      chk("e_no_listo", int'(bus.listo), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
